// File: rtl/cu_multi_reg.sv
// cu_multi_reg: PATP control unit with a bank of 2**REG_SEL_W data registers.
// One binary state machine (F1 F2 F3 E1 E2 E3 HALT) sequences fetch/execute
// over a shared bus. All strobes are decoded from state, op_q, rsel_q, z and
// mem_ready.
//
// Optional feature macro: CU_BNZ_EN (opcode 1001 becomes BNZ; otherwise NOP).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode[3:0], rsel   IR opcode and register-select fields (latched at end of F3)
//   z                   ALU zero flag (used by BUZ/BNZ in E1)
//   mem_ready           0 stalls read/write cycles
//   oe_ms/ir/pc/alureg  bus output enables; oe_d one-hot data-register OE
//   func[1:0]           ALU function: 00 CLR, 01 INC, 10 ADD, 11 DEC
//   read, write         memory strobes
//   we_mar/ir/pc/alureg write enables; we_d one-hot data-register WE
//   alu_bsel            latched rsel, ALU B-operand select
//   in_fetch, halted    status: F1..F3, HALT
module cu_multi_reg #(
  parameter int unsigned REG_SEL_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                opcode,
  input  logic [REG_SEL_W-1:0]      rsel,
  input  logic                      z,
  input  logic                      mem_ready,
  output logic                      oe_ms,
  output logic                      oe_ir,
  output logic                      oe_pc,
  output logic                      oe_alureg,
  output logic [(2**REG_SEL_W)-1:0] oe_d,
  output logic [1:0]                func,
  output logic                      read,
  output logic                      write,
  output logic                      we_mar,
  output logic                      we_ir,
  output logic                      we_pc,
  output logic                      we_alureg,
  output logic [(2**REG_SEL_W)-1:0] we_d,
  output logic [REG_SEL_W-1:0]      alu_bsel,
  output logic                      in_fetch,
  output logic                      halted
);

  localparam int unsigned NREG = 2**REG_SEL_W;

  localparam logic [3:0] OP_CLR   = 4'b0000;
  localparam logic [3:0] OP_INC   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_DEC   = 4'b0011;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_BUZ   = 4'b0101;
  localparam logic [3:0] OP_LOAD  = 4'b0110;
  localparam logic [3:0] OP_STORE = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1000;
`ifdef CU_BNZ_EN
  localparam logic [3:0] OP_BNZ   = 4'b1001;
`endif

  typedef enum logic [2:0] {
    F1   = 3'd0,
    F2   = 3'd1,
    F3   = 3'd2,
    E1   = 3'd3,
    E2   = 3'd4,
    E3   = 3'd5,
    HALT = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             op_q;
  logic [REG_SEL_W-1:0]   rsel_q;
  logic [NREG-1:0]        d_sel;

  assign d_sel = NREG'(1) << rsel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F1;
      op_q    <= '0;
      rsel_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == F3) begin
        op_q   <= opcode;
        rsel_q <= rsel;
      end
    end
  end

  // Outputs are forced low while rst is high, so an aborted instruction or
  // stall produces no strobes even in the first reset cycle.
  always_comb begin
    state_d   = state_q;
    oe_ms     = 1'b0;
    oe_ir     = 1'b0;
    oe_pc     = 1'b0;
    oe_alureg = 1'b0;
    oe_d      = '0;
    func      = 2'b00;
    read      = 1'b0;
    write     = 1'b0;
    we_mar    = 1'b0;
    we_ir     = 1'b0;
    we_pc     = 1'b0;
    we_alureg = 1'b0;
    we_d      = '0;
    alu_bsel  = '0;
    in_fetch  = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      alu_bsel = rsel_q;
      case (state_q)
        F1: begin
          in_fetch  = 1'b1;
          oe_pc     = 1'b1;
          we_mar    = 1'b1;
          func      = 2'b01;
          we_alureg = 1'b1;
          state_d   = F2;
        end
        F2: begin
          in_fetch = 1'b1;
          read     = 1'b1;
          oe_ms    = 1'b1;
          we_ir    = mem_ready;
          state_d  = mem_ready ? F3 : F2;
        end
        F3: begin
          in_fetch  = 1'b1;
          oe_alureg = 1'b1;
          we_pc     = 1'b1;
          state_d   = E1;
        end
        E1: begin
          state_d = F1;
          case (op_q)
            OP_CLR: begin
              func      = 2'b00;
              we_alureg = 1'b1;
              state_d   = E2;
            end
            OP_INC, OP_DEC: begin
              oe_d      = d_sel;
              func      = (op_q == OP_INC) ? 2'b01 : 2'b11;
              we_alureg = 1'b1;
              state_d   = E2;
            end
            OP_ADD, OP_LOAD, OP_STORE: begin
              oe_ir   = 1'b1;
              we_mar  = 1'b1;
              state_d = E2;
            end
            OP_JMP: begin
              oe_ir = 1'b1;
              we_pc = 1'b1;
            end
            OP_BUZ: begin
              oe_ir = z;
              we_pc = z;
            end
`ifdef CU_BNZ_EN
            OP_BNZ: begin
              oe_ir = !z;
              we_pc = !z;
            end
`endif
            OP_HALT: state_d = HALT;
            default: state_d = F1;
          endcase
        end
        E2: begin
          state_d = F1;
          case (op_q)
            OP_ADD: begin
              read      = 1'b1;
              oe_ms     = 1'b1;
              func      = 2'b10;
              we_alureg = mem_ready;
              state_d   = mem_ready ? E3 : E2;
            end
            OP_LOAD: begin
              read    = 1'b1;
              oe_ms   = 1'b1;
              we_d    = mem_ready ? d_sel : '0;
              state_d = mem_ready ? F1 : E2;
            end
            OP_STORE: begin
              oe_d    = d_sel;
              write   = 1'b1;
              state_d = mem_ready ? F1 : E2;
            end
            default: begin
              // CLR/INC/DEC write-back
              oe_alureg = 1'b1;
              we_d      = d_sel;
            end
          endcase
        end
        E3: begin
          oe_alureg = 1'b1;
          we_d      = d_sel;
          state_d   = F1;
        end
        HALT: begin
          halted  = 1'b1;
          state_d = HALT;
        end
        default: state_d = F1;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_multi_reg.sv
module tb_cu_multi_reg;

  localparam int W    = 2;
  localparam int NREG = 1 << W;
`ifdef CU_BNZ_EN
  localparam bit BNZ = 1'b1;
`else
  localparam bit BNZ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      opcode;
  logic [W-1:0]    rsel;
  logic            z, mem_ready;
  logic            oe_ms, oe_ir, oe_pc, oe_alureg;
  logic [NREG-1:0] oe_d;
  logic [1:0]      func;
  logic            read, write, we_mar, we_ir, we_pc, we_alureg;
  logic [NREG-1:0] we_d;
  logic [W-1:0]    alu_bsel;
  logic            in_fetch, halted;

  cu_multi_reg #(.REG_SEL_W(W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .rsel(rsel), .z(z), .mem_ready(mem_ready),
    .oe_ms(oe_ms), .oe_ir(oe_ir), .oe_pc(oe_pc), .oe_alureg(oe_alureg), .oe_d(oe_d),
    .func(func), .read(read), .write(write), .we_mar(we_mar), .we_ir(we_ir),
    .we_pc(we_pc), .we_alureg(we_alureg), .we_d(we_d), .alu_bsel(alu_bsel),
    .in_fetch(in_fetch), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            oe_ms, oe_ir, oe_pc, oe_alureg;
    logic [NREG-1:0] oe_d;
    logic [1:0]      func;
    logic            read, write, we_mar, we_ir, we_pc, we_alureg;
    logic [NREG-1:0] we_d;
    logic [W-1:0]    alu_bsel;
    logic            in_fetch, halted;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    mem;
  } step_t;

  typedef struct {
    logic [3:0]      op;
    logic [W-1:0]    rs;
    bit              zz;
    int unsigned     exp_exec;
    logic [NREG-1:0] exp_wed;
    bit              exp_wepc;
  } vec_t;

  outs_t act;
  assign act = {oe_ms, oe_ir, oe_pc, oe_alureg, oe_d, func, read, write, we_mar,
                we_ir, we_pc, we_alureg, we_d, alu_bsel, in_fetch, halted};

  int unsigned     nvec = 0, nerr = 0;
  step_t           plan[$];
  bit              mr_script[$];
  logic [W-1:0]    bsel_model = '0;
  int unsigned     exec_cnt, rd_cnt, rdwe_cnt;
  logic [NREG-1:0] wed_or;
  bit              wepc_exec;

  task automatic check(input string name, input outs_t e);
    nvec++;
    if (act !== e) begin
      nerr++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, e);
    end
  endtask

  task automatic cmp_int(input string name, input int unsigned got, input int unsigned want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input outs_t s, input bit mem);
    step_t st;
    st.o = s;
    st.mem = mem;
    plan.push_back(st);
  endtask

  // Reference: instruction -> list of micro-steps taken from the instruction table.
  task automatic build(input logic [3:0] op, input logic [W-1:0] rs, input bit zz);
    outs_t s;
    logic [NREG-1:0] d;
    d = NREG'(1) << rs;
    s = '0; s.in_fetch = 1; s.alu_bsel = bsel_model;
    s.oe_pc = 1; s.we_mar = 1; s.func = 2'b01; s.we_alureg = 1; push(s, 0);
    s = '0; s.in_fetch = 1; s.alu_bsel = bsel_model;
    s.read = 1; s.oe_ms = 1; s.we_ir = 1; push(s, 1);
    s = '0; s.in_fetch = 1; s.alu_bsel = bsel_model;
    s.oe_alureg = 1; s.we_pc = 1; push(s, 0);
    bsel_model = rs;
    s = '0; s.alu_bsel = rs;
    case (op)
      4'd0, 4'd1, 4'd3: begin
        if (op != 4'd0) s.oe_d = d;
        s.func = (op == 4'd0) ? 2'b00 : (op == 4'd1) ? 2'b01 : 2'b11;
        s.we_alureg = 1; push(s, 0);
        s = '0; s.alu_bsel = rs; s.oe_alureg = 1; s.we_d = d; push(s, 0);
      end
      4'd2: begin
        s.oe_ir = 1; s.we_mar = 1; push(s, 0);
        s = '0; s.alu_bsel = rs; s.read = 1; s.oe_ms = 1; s.func = 2'b10; s.we_alureg = 1;
        push(s, 1);
        s = '0; s.alu_bsel = rs; s.oe_alureg = 1; s.we_d = d; push(s, 0);
      end
      4'd4: begin s.oe_ir = 1; s.we_pc = 1; push(s, 0); end
      4'd5: begin s.oe_ir = zz; s.we_pc = zz; push(s, 0); end
      4'd6: begin
        s.oe_ir = 1; s.we_mar = 1; push(s, 0);
        s = '0; s.alu_bsel = rs; s.read = 1; s.oe_ms = 1; s.we_d = d; push(s, 1);
      end
      4'd7: begin
        s.oe_ir = 1; s.we_mar = 1; push(s, 0);
        s = '0; s.alu_bsel = rs; s.oe_d = d; s.write = 1; push(s, 1);
      end
      4'd9: begin s.oe_ir = BNZ && !zz; s.we_pc = BNZ && !zz; push(s, 0); end
      default: push(s, 0);  // HALT E1 and NOPs: no strobes
    endcase
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [W-1:0] rs, input bit zz,
                           input int unsigned stall_pct, input int unsigned abort_after);
    step_t st;
    outs_t e;
    bit stall;
    int unsigned n;
    build(op, rs, zz);
    exec_cnt = 0; wed_or = '0; wepc_exec = 0; rd_cnt = 0; rdwe_cnt = 0; n = 0;
    while (plan.size() != 0) begin
      st = plan[0];
      @(negedge clk);
      opcode = op; rsel = rs; z = zz;
      if (mr_script.size() != 0) mem_ready = mr_script.pop_front();
      else mem_ready = ($urandom_range(99) >= stall_pct);
      stall = st.mem && !mem_ready;
      e = st.o;
      if (stall) begin
        e.we_mar = 0; e.we_ir = 0; e.we_pc = 0; e.we_alureg = 0; e.we_d = '0;
      end
      #1;
      check($sformatf("op%h_step%0d", op, n), e);
      if (!act.in_fetch && !act.halted) exec_cnt++;
      if (!act.in_fetch) wepc_exec |= act.we_pc;
      wed_or |= act.we_d;
      if (act.read) rd_cnt++;
      if (act.read && act.we_alureg) rdwe_cnt++;
      if (!stall) void'(plan.pop_front());
      n++;
      if (abort_after != 0 && n >= abort_after) break;
    end
  endtask

  task automatic halt_check(input int unsigned n);
    outs_t e;
    repeat (n) begin
      @(negedge clk);
      mem_ready = $urandom_range(1);
      z = $urandom_range(1);
      e = '0; e.halted = 1; e.alu_bsel = bsel_model;
      #1 check("halt", e);
    end
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(negedge clk);
    rst = 1;
    mem_ready = $urandom_range(1);
    #1 check("reset", '0);
    repeat (cycles - 1) begin
      @(negedge clk);
      #1 check("reset", '0);
    end
    @(posedge clk);
    #1 rst = 0;
    plan.delete();
    mr_script.delete();
    bsel_model = '0;
  endtask

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; opcode = '0; rsel = '0; z = 0; mem_ready = 1;

    tbl[0]  = '{4'h0, 2'd0, 1'b0, 2, 4'b0001, 1'b0};
    tbl[1]  = '{4'h1, 2'd2, 1'b0, 2, 4'b0100, 1'b0};
    tbl[2]  = '{4'h3, 2'd1, 1'b1, 2, 4'b0010, 1'b0};
    tbl[3]  = '{4'h2, 2'd1, 1'b0, 3, 4'b0010, 1'b0};
    tbl[4]  = '{4'h4, 2'd3, 1'b0, 1, 4'b0000, 1'b1};
    tbl[5]  = '{4'h5, 2'd0, 1'b0, 1, 4'b0000, 1'b0};
    tbl[6]  = '{4'h5, 2'd0, 1'b1, 1, 4'b0000, 1'b1};
    tbl[7]  = '{4'h6, 2'd3, 1'b0, 2, 4'b1000, 1'b0};
    tbl[8]  = '{4'h7, 2'd3, 1'b1, 2, 4'b0000, 1'b0};
    tbl[9]  = '{4'hA, 2'd2, 1'b0, 1, 4'b0000, 1'b0};
    tbl[10] = '{4'h9, 2'd1, 1'b0, 1, 4'b0000, BNZ};
    tbl[11] = '{4'h9, 2'd1, 1'b1, 1, 4'b0000, 1'b0};
    tbl[12] = '{4'hF, 2'd3, 1'b1, 1, 4'b0000, 1'b0};

    do_reset(2);

    // Directed table, no stalls.
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].op, tbl[i].rs, tbl[i].zz, 0, 0);
      cmp_int($sformatf("tbl%0d_exec", i), exec_cnt, tbl[i].exp_exec);
      cmp_int($sformatf("tbl%0d_wed", i), wed_or, tbl[i].exp_wed);
      cmp_int($sformatf("tbl%0d_wepc", i), wepc_exec, tbl[i].exp_wepc);
    end

    // ADD rsel=1 with three stall cycles in E2.
    mr_script = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
    run_instr(4'h2, 2'd1, 1'b0, 0, 0);
    cmp_int("add_stall_read", rd_cnt, 5);
    cmp_int("add_stall_rdwe", rdwe_cnt, 1);
    cmp_int("add_stall_exec", exec_cnt, 6);
    cmp_int("add_stall_wed", wed_or, 4'b0010);

    // Fetch stall of two cycles.
    mr_script = '{1, 0, 0, 1, 1};
    run_instr(4'h1, 2'd0, 1'b0, 0, 0);
    cmp_int("fetch_stall_read", rd_cnt, 3);

    // STORE r3 then HALT, sit halted, reset back to fetch.
    run_instr(4'h7, 2'd3, 1'b0, 0, 0);
    run_instr(4'h8, 2'd2, 1'b0, 0, 0);
    halt_check(20);
    do_reset(1);
    run_instr(4'h4, 2'd0, 1'b0, 0, 0);

    // Reset mid-stall of a LOAD.
    mr_script = '{1, 1, 1, 1, 0, 0, 0};
    run_instr(4'h6, 2'd2, 1'b0, 0, 6);
    do_reset(1);

    // Randomized instructions with random stalls and occasional aborts.
    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      logic [W-1:0] rs;
      bit zz;
      int unsigned ab;
      op = 4'($urandom_range(15));
      rs = W'($urandom_range(NREG - 1));
      zz = 1'($urandom_range(1));
      ab = ($urandom_range(19) == 0) ? $urandom_range(1, 5) : 0;
      run_instr(op, rs, zz, 25, ab);
      if (ab != 0) do_reset($urandom_range(1, 2));
      else if (op == 4'h8) begin
        halt_check($urandom_range(1, 6));
        do_reset($urandom_range(1, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cu_multi_reg.md
Name: cu_multi_reg

Overview:
Parametrised next-generation PATP control unit. Sequences fetch/execute over a shared bus and drives output/write enables for MS, IR, PC, MAR, ALUREG and a bank of 2**REG_SEL_W data registers. Compared with the single-D0 unit it adds:
- a 4-bit opcode with a register-select field
- a memory-ready stall handshake
- a HALT instruction
- a single binary state machine in place of separate FF/sequencer blocks

Parameters:
REG_SEL_W, 2, width of register-select field; NREG = 2**REG_SEL_W data registers (REG_SEL_W >= 1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
opcode  input  4  IR opcode field
rsel  input  REG_SEL_W  IR register-select field
z  input  1  ALU zero flag
mem_ready  input  1  memory ready; 0 stalls read/write cycles
oe_ms, oe_ir, oe_pc, oe_alureg  output  1 each  bus output enables
oe_d  output  NREG  one-hot data-register output enable
func  output  2  ALU function: 00 CLR, 01 INC, 10 ADD, 11 DEC
read, write  output  1 each  memory strobes
we_mar, we_ir, we_pc, we_alureg  output  1 each  write enables
we_d  output  NREG  one-hot data-register write enable
alu_bsel  output  REG_SEL_W  latched rsel; selects ALU B operand
in_fetch  output  1  high in F1..F3
halted  output  1  high in HALT state

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - While rst=1 all outputs are 0.
  - Next state is F1; op_q, rsel_q and halted are cleared.
  - rst asserted mid-instruction or mid-stall aborts it with no further strobes.
- States: F1, F2, F3, E1, E2, E3, HALT. All strobes are decoded from state, op_q, rsel_q, z and mem_ready.
- Fetch sequence:
  - F1: oe_pc, we_mar, func=01, we_alureg (PC+1 into ALUREG).
  - F2: read, oe_ms, we_ir.
  - F3: oe_alureg, we_pc. At end of F3, op_q<=opcode and rsel_q<=rsel. Go to E1.
- Stall:
  - In any state asserting read or write, if mem_ready=0 the state holds and strobes stay asserted.
  - Every we_* in that state is gated by mem_ready, so a write occurs only on the completing cycle.
  - No limit on stall length.
- Execute sequences (D = register selected by rsel_q; oe_d/we_d are one-hot on rsel_q):
  - 0000 CLR: E1 func=00, we_alureg; E2 oe_alureg, we_d. Then F1.
  - 0001 INC: E1 oe_d, func=01, we_alureg; E2 oe_alureg, we_d. Then F1.
  - 0011 DEC: as INC with func=11.
  - 0010 ADD: E1 oe_ir, we_mar; E2 read, oe_ms, func=10, we_alureg (bus + D via alu_bsel); E3 oe_alureg, we_d. Then F1.
  - 0100 JMP: E1 oe_ir, we_pc. Then F1.
  - 0101 BUZ: E1 oe_ir, we_pc if z=1; otherwise no strobes. Then F1.
  - 0110 LOAD: E1 oe_ir, we_mar; E2 read, oe_ms, we_d. Then F1.
  - 0111 STORE: E1 oe_ir, we_mar; E2 oe_d, write. Then F1.
  - 1000 HALT: E1 no strobes, then HALT. HALT asserts halted=1, all strobes 0, and is left only by rst.
  - 1001..1111: NOP; E1 no strobes, then F1 (1001 changes only under the optional feature).
- alu_bsel = rsel_q at all times; reset value 0.
- Bus rule: at most one oe_* (including oe_d bits) is high in any cycle; read and write are never both high.
- Latency: JMP/BUZ/NOP = 4 cycles; CLR/INC/DEC/LOAD/STORE = 5; ADD = 6. Add one cycle per stall cycle.

Optional Feature:
CU_BNZ_EN
- Defined: opcode 1001 = BNZ. E1 asserts oe_ir, we_pc if z=0; no strobes if z=1. Then F1.
- Undefined: 1001 is a NOP.

Test Plan:
- rst high 2 cycles then released, mem_ready=1 -> all outputs 0 during reset; next cycle F1 with oe_pc=we_mar=we_alureg=1, func=01, in_fetch=1.
- REG_SEL_W=2, IR = INC with rsel=2 -> E1 oe_d=0100, func=01, we_alureg=1; E2 we_d=0100; F1 at cycle 6.
- ADD rsel=1 with mem_ready low 3 cycles in E2 -> read/oe_ms held 4 cycles, we_alureg high only on the 4th, alu_bsel=1; we_d=0010 in E3.
- BUZ with z=0, then BUZ with z=1 -> no we_pc in the first; oe_ir and we_pc in E1 of the second; each instruction takes 4 cycles.
- STORE rsel=3 followed by HALT -> E2 oe_d=1000, write=1; after HALT, halted=1 with no strobes for 20 cycles; rst returns to F1.
- Opcode 1001 with z=0 -> we_pc in E1 only when CU_BNZ_EN is defined; otherwise no strobes.
